pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The parameters SHALL be:
- XLEN, 32, PC/data width.
- STEP, 1, address increment per instruction: 1 = word-addressed, 4 = byte-addressed; no other values.
- RESET_VECTOR, 0, PC value after reset.
- EXC_VECTOR, 32'h80, PC value on exception.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.

REQ-002 The ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- exc  in  1  exception redirect request.
- pc_src  in  2  00 sequential, 01 jump (J/JAL), 10 taken branch, 11 jump-register.
- is_link  in  1  with pc_src=01, the jump is JAL.
- is_ret  in  1  with pc_src=11, the JR source is $ra.
- imm16  in  16  branch offset.
- addr26  in  26  jump target field.
- rs_val  in  XLEN  JR target.
- pc  out  XLEN  current PC (register).
- pc_plus  out  XLEN  pc+STEP (combinational).
- link_we  out  1  write $31 this cycle (combinational).
- link_val  out  XLEN  value for $31, equal to pc_plus.
- ras_top  out  XLEN  predicted return address (combinational).
- ras_empty  out  1  RAS holds no entries.
- ras_miss  out  1  registered one-cycle pulse: return mispredicted.
- ras_ovf  out  1  registered one-cycle pulse: push overwrote oldest entry.
- ras_unf  out  1  registered one-cycle pulse: pop on empty RAS.

Function
REQ-003 Next PC SHALL be selected with priority exc > stall > pc_src.
- exc: EXC_VECTOR.
- stall: pc held.
- pc_src 00: pc_plus.
- pc_src 10: branch target.
- pc_src 01: jump target.
- pc_src 11: rs_val.
REQ-004 Branch target SHALL be pc_plus + (sext(imm16) * STEP), truncated to XLEN bits, wrapping modulo 2^XLEN.
REQ-005 Jump target SHALL be formed as follows:
- STEP=1: {pc_plus[XLEN-1:26], addr26}.
- STEP=4: {pc_plus[XLEN-1:28], addr26, 2'b00}.
REQ-006 pc SHALL update only on the rising edge of clk; pc_plus SHALL wrap modulo 2^XLEN.
REQ-007 link_we SHALL be 1 iff pc_src=01 and is_link=1 and stall=0 and exc=0.
REQ-008 A push SHALL occur when link_we=1; it writes pc_plus to the RAS.
REQ-009 A pop SHALL occur when pc_src=11 and is_ret=1 and stall=0 and exc=0.
REQ-010 The RAS SHALL be a circular buffer with a top pointer and an occupancy count 0..RAS_DEPTH; push and pop are mutually exclusive by construction.
REQ-011 Push with count=RAS_DEPTH SHALL overwrite the oldest entry, keep count at RAS_DEPTH, and pulse ras_ovf on the next cycle.
REQ-012 Pop with count=0 SHALL leave pointer and count unchanged and pulse ras_unf and ras_miss on the next cycle.
REQ-013 Pop with count>0 SHALL decrement count; ras_miss SHALL pulse on the next cycle iff the pre-pop ras_top != rs_val.
REQ-014 The PC SHALL always load rs_val on JR; the RAS is prediction only and never redirects the PC.
REQ-015 ras_top SHALL equal the top entry when count>0, and 0 when count=0.
REQ-016 exc SHALL leave the RAS and count unchanged.
REQ-017 ras_miss, ras_ovf and ras_unf SHALL each be high for exactly one cycle per event and 0 otherwise.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously reset pc to RESET_VECTOR, RAS count and pointer to 0, and ras_miss/ras_ovf/ras_unf to 0.
REQ-019 RAS entry contents SHALL NOT need reset.
REQ-020 Reset asserted mid-operation SHALL discard any pending push, pop or pulse.
REQ-021 The first clk edge after rst_n rises SHALL apply normal next-PC selection.

Verification
REQ-022 Sequential, STEP=4: reset, then 3 cycles with pc_src=00 -> pc = 0, 4, 8, 12.
REQ-023 Branch, STEP=4: pc=0x100, pc_src=10, imm16=0xFFFE -> next pc=0xFC; imm16=0x0003 -> next pc=0x110.
REQ-024 JAL then return, STEP=1: pc=0x10, pc_src=01, is_link=1, addr26=0x40 -> link_we=1, link_val=0x11, next pc=0x40, ras_top=0x11. Later pc_src=11, is_ret=1, rs_val=0x11 -> pc=0x11, ras_miss stays 0, ras_empty=1.
REQ-025 RAS overflow/underflow, RAS_DEPTH=4: five JALs -> ras_ovf pulses once, on the fifth. Five returns -> the first four pop the last four pushes in LIFO order, and the fifth pulses ras_unf and ras_miss.
REQ-026 Priority: exc=1 and stall=1 together with pc_src=01, is_link=1 -> pc=EXC_VECTOR, link_we=0, RAS unchanged. stall=1 alone -> pc held and no push.
REQ-027 Reset mid-run: rst_n low asynchronously between edges -> pc=RESET_VECTOR immediately, ras_empty=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with a circular return-address stack for JAL/JR $ra prediction.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              STEP         = 1,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h80,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            exc,
    input  logic [1:0]      pc_src,
    input  logic            is_link,
    input  logic            is_ret,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [XLEN-1:0] rs_val,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            link_we,
    output logic [XLEN-1:0] link_val,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_miss,
    output logic            ras_ovf,
    output logic            ras_unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            push, pop, full;
    logic [XLEN-1:0] sx, br_tgt, j_tgt, pc_next;

    assign pc_plus   = pc + XLEN'(STEP);
    assign link_val  = pc_plus;
    assign sx        = {{(XLEN-16){imm16[15]}}, imm16};
    assign br_tgt    = pc_plus + (STEP == 4 ? {sx[XLEN-3:0], 2'b00} : sx);
    assign j_tgt     = STEP == 4 ? {pc_plus[XLEN-1:28], addr26, 2'b00} : {pc_plus[XLEN-1:26], addr26};
    assign link_we   = pc_src == 2'b01 && is_link && !stall && !exc;
    assign push      = link_we;
    assign pop       = pc_src == 2'b11 && is_ret && !stall && !exc;
    assign ras_empty = cnt == '0;
    assign full      = cnt == CW'(RAS_DEPTH);
    // ptr names the next free slot, so the top entry sits one below it
    assign ras_top   = ras_empty ? '0 : ras[ptr - PW'(1)];

    always_comb begin
        pc_next = exc             ? EXC_VECTOR :
                  stall           ? pc         :
                  pc_src == 2'b00 ? pc_plus    :
                  pc_src == 2'b10 ? br_tgt     :
                  pc_src == 2'b01 ? j_tgt      : rs_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            ptr      <= '0;
            cnt      <= '0;
            ras_miss <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
        end else begin
            pc       <= pc_next;
            ptr      <= push ? ptr + PW'(1) : (pop && !ras_empty) ? ptr - PW'(1) : ptr;
            cnt      <= push ? (full ? cnt : cnt + CW'(1)) : (pop && !ras_empty) ? cnt - CW'(1) : cnt;
            ras_ovf  <= push && full;
            ras_unf  <= pop && ras_empty;
            ras_miss <= pop && (ras_empty || ras_top != rs_val);
        end
    end

    // When full, the free slot is the oldest entry, so a push overwrites it naturally
    always_ff @(posedge clk) begin
        if (push) ras[ptr] <= pc_plus;
    end
endmodule
